// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the multi-channel clock divider.
// The board clock rate and the divisors for common rates are kept here so the
// timekeeping logic and the divider share one source of truth.
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 27;
    localparam int unsigned CLK_HZ    = 100_000_000;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Divisors for the 100 MHz board clock.
    localparam int unsigned DIV_1HZ  = 100_000_000;
    localparam int unsigned DIV_1KHZ = 100_000;
    localparam int unsigned DIV_2HZ  = 50_000_000;

endpackage : clk_div_pkg

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: counter, active divisor, pending divisor, tick and
// square-wave outputs. The caller decides when the channel advances.
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   rst         asynchronous active-high reset
//   en_i        channel enable (an idle channel applies a pending divisor at once)
//   adv_i       advance this edge (already qualified by enable/clear/cascade)
//   clr_i       synchronous clear, overrides advancing
//   load_i      divisor load strobe
//   div_i       divisor value captured on load_i
//   tick_o      one-cycle pulse at the end of every period
//   sq_o        square wave, low for floor(D/2) cycles then high for the rest
//   pend_o      a loaded divisor is waiting for the period boundary
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_1HZ)
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             en_i,
    input  logic             adv_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;
    logic             xfer;

    always_comb begin
        // Divisors 0 and 1 both behave as divide-by-one.
        div_eff = (div_q <= CNT_W'(1)) ? CNT_W'(1) : div_q;
        cnt_inc = cnt_q + CNT_W'(1);
        wrap    = adv_i && (cnt_q == div_eff - CNT_W'(1));
        // An idle channel has no period boundary to wait for.
        xfer    = pend_q && (wrap || !en_i);

        // NOTE: every next-state signal gets a default here so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;

        if (clr_i) begin
            cnt_d  = '0;
            sq_d   = 1'b0;
            pend_d = 1'b0;
            if (pend_q) div_d = pend_div_q;
            // A load coinciding with clear is applied directly.
            if (load_i) div_d = div_i;
        end else begin
            if (adv_i) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    sq_d  = (cnt_inc >= (div_q >> 1));
                end
            end
            // A transfer always restarts the period so cnt never exceeds the
            // new divisor.
            if (xfer) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
                cnt_d  = '0;
                sq_d   = 1'b0;
            end
            // A load on the transfer edge becomes the next pending value.
            if (load_i) begin
                pend_div_d = div_i;
                pend_d     = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_div_q <= RST_DIV;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign pend_o = pend_q;

endmodule : clk_div_channel

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent programmable dividers off the 100 MHz board clock, each
// producing a one-cycle tick and a near-50% square wave. Divisor loads are
// applied at period boundaries so no short or long period is ever produced.
//
// Build option: define CLK_DIV_CASCADE_EN to chain the channels; channel k>0
// then advances only when channel k-1 ticked on the previous cycle
// (e.g. seconds -> minutes -> hours).
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   rst         asynchronous active-high reset
//   en_i        per-channel count enable
//   clr_i       synchronous clear of all channels
//   load_i      per-channel divisor load strobe
//   div_i       flat divisors, channel k at [k*CNT_W +: CNT_W]
//   tick_o      per-channel one-cycle pulse per period
//   sq_o        per-channel square wave
//   pend_o      per-channel loaded divisor waiting for its period boundary
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
    input  logic                    clk_100MHz,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    clr_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       sq_o,
    output logic [NUM_CH-1:0]       pend_o
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] adv;

    assign adv[0] = en_i[0] && !clr_i;

    for (genvar k = 1; k < NUM_CH; k++) begin : g_adv
`ifdef CLK_DIV_CASCADE_EN
        // Registered tick of the previous stage: one cycle of delay per stage.
        assign adv[k] = en_i[k] && tick_o[k-1] && !clr_i;
`else
        assign adv[k] = en_i[k] && !clr_i;
`endif
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .rst        (rst),
            .en_i       (en_i[k]),
            .adv_i      (adv[k]),
            .clr_i      (clr_i),
            .load_i     (load_i[k]),
            .div_i      (div_i[k*CNT_W +: CNT_W]),
            .tick_o     (tick_o[k]),
            .sq_o       (sq_o[k]),
            .pend_o     (pend_o[k])
        );
    end

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi with DEFAULT_DIV = 10. Inputs change and
// outputs are sampled 1 ns after each rising edge; "edge e" counts rising
// edges since the last reset release or clear.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 27;

    logic                    clk_100MHz = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en_i;
    logic                    clr_i;
    logic [NUM_CH-1:0]       load_i;
    logic [NUM_CH*CNT_W-1:0] div_i;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       sq_o;
    logic [NUM_CH-1:0]       pend_o;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (10)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .load_i     (load_i),
        .div_i      (div_i),
        .tick_o     (tick_o),
        .sq_o       (sq_o),
        .pend_o     (pend_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_div(input int ch, input int unsigned val);
        div_i[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Clear all channels while loading ch0/ch1 directly.
    task automatic restart(input int unsigned d0, input int unsigned d1);
        set_div(0, d0);
        set_div(1, d1);
        load_i = 4'b0011;
        clr_i  = 1'b1;
        step();
        load_i = '0;
        clr_i  = 1'b0;
        check("restart_pend", pend_o, 4'b0000);
        check("restart_tick", tick_o, 4'b0000);
        check("restart_sq",   sq_o,   4'b0000);
    endtask

    initial begin
        rst    = 1'b1;
        en_i   = '1;
        clr_i  = 1'b0;
        load_i = '0;
        div_i  = '0;

        // 1. Reset held with all enables high, then D = 10 from DEFAULT_DIV.
        repeat (3) begin
            step();
            check("rst_tick", tick_o, 4'b0000);
            check("rst_sq",   sq_o,   4'b0000);
            check("rst_pend", pend_o, 4'b0000);
        end
        rst = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            check($sformatf("t1_tick e%0d", e), tick_o[0], (e % 10) == 0);
            check($sformatf("t1_sq e%0d", e),   sq_o[0],   (e % 10) >= 5);
        end

        // 2. Square duty: ch0 D = 4 (low 2/high 2), ch1 D = 5 (low 2/high 3).
        restart(4, 5);
        for (int e = 1; e <= 20; e++) begin
            step();
            check($sformatf("t2_sq0 e%0d", e),   sq_o[0],   (e % 4) >= 2);
            check($sformatf("t2_sq1 e%0d", e),   sq_o[1],   (e % 5) >= 2);
            check($sformatf("t2_tick0 e%0d", e), tick_o[0], (e % 4) == 0);
            check($sformatf("t2_tick1 e%0d", e), tick_o[1], (e % 5) == 0);
        end

        // 3. Glitch-free load: D = 8, load 3 while cnt = 2.
        restart(8, 5);
        step();
        step();
        set_div(0, 3);
        load_i = 4'b0001;
        step();
        load_i = '0;
        check("t3_pend_e3", pend_o[0], 1'b1);
        for (int e = 4; e <= 7; e++) begin
            step();
            check($sformatf("t3_pend e%0d", e), pend_o[0], 1'b1);
            check($sformatf("t3_tick e%0d", e), tick_o[0], 1'b0);
        end
        step();
        check("t3_wrap_tick", tick_o[0], 1'b1);
        check("t3_wrap_pend", pend_o[0], 1'b0);
        for (int e = 9; e <= 14; e++) begin
            step();
            check($sformatf("t3_tick e%0d", e), tick_o[0], ((e - 8) % 3) == 0);
            check($sformatf("t3_sq e%0d", e),   sq_o[0],   ((e - 8) % 3) >= 1);
        end

        // 4. Enable gap of 5 cycles at cnt = 5 delays the tick by exactly 5.
        restart(8, 5);
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("t4_tick e%0d", e), tick_o[0], 1'b0);
        end
        check("t4_sq_cnt5", sq_o[0], 1'b1);
        en_i[0] = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("t4_hold_tick %0d", e), tick_o[0], 1'b0);
            check($sformatf("t4_hold_sq %0d", e),   sq_o[0],   1'b1);
        end
        en_i[0] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("t4_resume_tick %0d", e), tick_o[0], e == 3);
        end
        repeat (6) step();
        check("t4_sq_before_clr", sq_o[0], 1'b1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("t4_clr_tick", tick_o[0], 1'b0);
        check("t4_clr_sq",   sq_o[0],   1'b0);
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("t4_clr_next e%0d", e), tick_o[0], e == 8);
        end
        // Idle channel applies a load on the very next edge.
        en_i[2] = 1'b0;
        set_div(2, 6);
        load_i = 4'b0100;
        step();
        load_i = '0;
        check("t4_idle_pend_set", pend_o[2], 1'b1);
        step();
        check("t4_idle_pend_clr", pend_o[2], 1'b0);
        en_i[2] = 1'b1;

        // 5. Degenerate divisors 0 and 1, then D = 2.
        restart(0, 1);
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("t5_tick e%0d", e), tick_o[1:0], 2'b11);
            check($sformatf("t5_sq e%0d", e),   sq_o[1:0],   2'b00);
        end
        set_div(0, 2);
        set_div(1, 2);
        load_i = 4'b0011;
        step();
        load_i = '0;
        check("t5_load_pend", pend_o[1:0], 2'b11);
        check("t5_load_tick", tick_o[1:0], 2'b11);
        step();
        check("t5_xfer_pend", pend_o[1:0], 2'b00);
        check("t5_xfer_tick", tick_o[1:0], 2'b11);
        check("t5_xfer_sq",   sq_o[1:0],   2'b00);
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("t5_d2_tick e%0d", e), tick_o[1:0], (e % 2 == 0) ? 2'b11 : 2'b00);
            check($sformatf("t5_d2_sq e%0d", e),   sq_o[1:0],   (e % 2 == 1) ? 2'b11 : 2'b00);
        end

        // 6. ch0 D = 5, ch1 D = 3, cascaded or independent.
        restart(5, 3);
        for (int e = 1; e <= 32; e++) begin
            step();
            check($sformatf("t6_tick0 e%0d", e), tick_o[0], (e % 5) == 0);
`ifdef CLK_DIV_CASCADE_EN
            check($sformatf("t6_tick1 e%0d", e), tick_o[1], (e > 1) && ((e % 15) == 1));
`else
            check($sformatf("t6_tick1 e%0d", e), tick_o[1], (e % 3) == 0);
`endif
        end

        // 7. Asynchronous reset with a divisor pending: it is discarded.
        set_div(0, 7);
        load_i = 4'b0001;
        step();
        load_i = '0;
        check("t7_pend_before_rst", pend_o[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t7_async_pend", pend_o, 4'b0000);
        check("t7_async_tick", tick_o, 4'b0000);
        check("t7_async_sq",   sq_o,   4'b0000);
        step();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("t7_default e%0d", e), tick_o[0], e == 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clk_div_multi
